// File: rtl/rbl_read_sequencer.sv
// rbl_read_sequencer: shares one read bit line between NREQ requesters.
// Each access goes IDLE -> PRE (precharge) -> EVAL (word line) -> CAP (deliver bit).
// Optional macro RBL_PCH_CHECK_EN: enables the sticky precharge fault flag pch_err.
module rbl_read_sequencer #(
  parameter int NREQ     = 2,
  parameter int NROWS    = 4,
  parameter int AW       = 2,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 pch,
  output logic [NROWS-1:0]     rwl,
  input  logic                 rbl,
  output logic [NREQ-1:0]      rvalid,
  output logic                 rdata,
  output logic                 pch_err
);

  localparam int IDW  = $clog2(NREQ);
  localparam int MAXC = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_EVAL, S_CAP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CNTW-1:0] r_cnt;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  w_arb_id;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   w_arb_addr;
  logic            r_data;
  logic            w_arb;
  logic            w_last;
  logic [NREQ-1:0] w_rot;

  // Requests rotated so bit 0 is the requester right after the last grantee.
  assign w_rot = NREQ'({req, req} >> (int'(r_id) + 1));

  // Round-robin pick: lowest set bit of the rotated vector wins; mux its address.
  always_comb begin
    w_arb_id   = '0;
    w_arb_addr = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_arb_id = IDW'((int'(r_id) + 1 + k) % NREQ);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_id == IDW'(i)) w_arb_addr = addr[i*AW +: AW];
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_arb        = 1'b0;
    w_last       = (r_state == S_PRE) ? (r_cnt == CNTW'(PRE_CYC - 1))
                                      : (r_cnt == CNTW'(EVAL_CYC - 1));
    case (r_state)
      S_IDLE: if (|req) begin
                w_state_next = S_PRE;
                w_arb        = 1'b1;
              end
      S_PRE:  if (w_last) w_state_next = S_EVAL;
      S_EVAL: if (w_last) w_state_next = S_CAP;
      S_CAP:  if (|req) begin
                w_state_next = S_PRE;
                w_arb        = 1'b1;
              end else begin
                w_state_next = S_IDLE;
              end
      default: w_state_next = S_IDLE;
    endcase
    busy  = (r_state != S_IDLE);
    pch   = (r_state == S_PRE);
    rdata = (r_state == S_CAP) && r_data;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i]    = (r_state == S_PRE) && (r_cnt == '0) && (r_id == IDW'(i));
      rvalid[i] = (r_state == S_CAP) && (r_id == IDW'(i));
    end
  end

  // Word lines: only the latched row, only during EVAL; out-of-range rows decode to zero.
  genvar gi;
  generate
    for (gi = 0; gi < NROWS; gi++) begin : g_rwl
      assign rwl[gi] = (r_state == S_EVAL) && (r_addr == AW'(gi));
    end
  endgenerate

  // State, phase counter, latched grant/address and captured bit.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_id    <= IDW'(NREQ - 1);
      r_addr  <= '0;
      r_data  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (w_state_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      if (w_arb) begin
        r_id   <= w_arb_id;
        r_addr <= w_arb_addr;
      end
      // With no word line raised the bit line stays precharged, so the result is 1.
      if (r_state == S_EVAL && w_last) r_data <= (|rwl) ? rbl : 1'b1;
    end
  end

`ifdef RBL_PCH_CHECK_EN
  logic r_pch_err;

  // Sticky flag: bit line failed to reach the precharged level by the end of PRE.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_pch_err <= 1'b0;
    end else if (r_state == S_PRE && w_last && !rbl) begin
      r_pch_err <= 1'b1;
    end
  end

  assign pch_err = r_pch_err;
`else
  assign pch_err = 1'b0;
`endif

endmodule

// File: tb/tb_rbl_read_sequencer.sv
// Directed, table-driven bench for rbl_read_sequencer (NREQ=2, AW=2; NROWS=4 and NROWS=3 instances).
module tb_rbl_read_sequencer;

  logic       clk = 1'b0;
  logic       reset_l;
  logic [1:0] req, gnt, rvalid;
  logic [3:0] addr, rwl;
  logic       rbl, busy, pch, rdata, pch_err;

  logic [1:0] req3, gnt3, rvalid3;
  logic [3:0] addr3;
  logic [2:0] rwl3;
  logic       rbl3, busy3, pch3, rdata3, pch_err3;

  int n_checks = 0;
  int n_errors = 0;

`ifdef RBL_PCH_CHECK_EN
  localparam logic EXP_PE = 1'b1;
`else
  localparam logic EXP_PE = 1'b0;
`endif

  always #5 clk = ~clk;

  rbl_read_sequencer #(.NREQ(2), .NROWS(4), .AW(2), .PRE_CYC(1), .EVAL_CYC(1)) u_dut (
    .clk(clk), .reset_l(reset_l), .req(req), .addr(addr), .gnt(gnt), .busy(busy),
    .pch(pch), .rwl(rwl), .rbl(rbl), .rvalid(rvalid), .rdata(rdata), .pch_err(pch_err));

  rbl_read_sequencer #(.NREQ(2), .NROWS(3), .AW(2), .PRE_CYC(1), .EVAL_CYC(1)) u_dut3 (
    .clk(clk), .reset_l(reset_l), .req(req3), .addr(addr3), .gnt(gnt3), .busy(busy3),
    .pch(pch3), .rwl(rwl3), .rbl(rbl3), .rvalid(rvalid3), .rdata(rdata3), .pch_err(pch_err3));

  // Observed bundle: {gnt, busy, pch, rwl, rvalid, rdata, pch_err}
  logic [11:0] obs;
  assign obs = {gnt, busy, pch, rwl, rvalid, rdata, pch_err};

  typedef struct {
    logic        rst_l;
    logic [1:0]  req;
    logic [3:0]  addr;
    logic        rbl;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] mk(logic [1:0] g, logic b, logic p, logic [3:0] rw,
                                     logic [1:0] rv, logic rd);
    return {g, b, p, rw, rv, rd, 1'b0};
  endfunction

  task automatic add(logic rst_l, logic [1:0] rq, logic [3:0] ad, logic rb, logic [11:0] ex);
    vec_t v;
    v.rst_l = rst_l; v.req = rq; v.addr = ad; v.rbl = rb; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [11:0] Z = 12'h000;

  initial begin
    reset_l = 1'b0; req = '0; addr = '0; rbl = 1'b1;
    req3 = '0; addr3 = '0; rbl3 = 1'b1;

    // Reset, then single read of row 2 by requester 0 with rbl=0 in EVAL
    add(0, 2'b00, 4'h0,    1, Z);
    add(0, 2'b00, 4'h0,    1, Z);
    add(1, 2'b01, 4'b0010, 1, mk(2'b01, 1, 1, 4'b0000, 2'b00, 0));
    add(1, 2'b00, 4'b0010, 1, mk(2'b00, 1, 0, 4'b0100, 2'b00, 0));
    add(1, 2'b00, 4'b0010, 0, mk(2'b00, 1, 0, 4'b0000, 2'b01, 0));
    add(1, 2'b00, 4'h0,    1, Z);
    // Both requesting: alternating grants, back-to-back every 3 cycles
    add(0, 2'b00, 4'h0,    1, Z);
    add(1, 2'b11, 4'b1001, 1, mk(2'b01, 1, 1, 4'b0000, 2'b00, 0));
    add(1, 2'b11, 4'b1001, 1, mk(2'b00, 1, 0, 4'b0010, 2'b00, 0));
    add(1, 2'b11, 4'b1001, 1, mk(2'b00, 1, 0, 4'b0000, 2'b01, 1));
    add(1, 2'b11, 4'b1001, 1, mk(2'b10, 1, 1, 4'b0000, 2'b00, 0));
    add(1, 2'b11, 4'b1001, 1, mk(2'b00, 1, 0, 4'b0100, 2'b00, 0));
    add(1, 2'b11, 4'b1001, 0, mk(2'b00, 1, 0, 4'b0000, 2'b10, 0));
    add(1, 2'b11, 4'b1001, 1, mk(2'b01, 1, 1, 4'b0000, 2'b00, 0));
    add(1, 2'b11, 4'b1001, 1, mk(2'b00, 1, 0, 4'b0010, 2'b00, 0));
    add(1, 2'b11, 4'b1001, 1, mk(2'b00, 1, 0, 4'b0000, 2'b01, 1));
    add(1, 2'b11, 4'b1001, 1, mk(2'b10, 1, 1, 4'b0000, 2'b00, 0));
    add(1, 2'b11, 4'b1001, 1, mk(2'b00, 1, 0, 4'b0100, 2'b00, 0));
    add(1, 2'b11, 4'b1001, 1, mk(2'b00, 1, 0, 4'b0000, 2'b10, 1));
    add(1, 2'b11, 4'b1001, 1, mk(2'b01, 1, 1, 4'b0000, 2'b00, 0));
    // Reset mid-access: aborted, no rvalid afterwards
    add(0, 2'b11, 4'b1001, 1, Z);
    add(0, 2'b11, 4'b1001, 1, Z);
    add(1, 2'b00, 4'h0,    1, Z);
    add(1, 2'b00, 4'h0,    1, Z);
    // Requester 1 alone, row 3, continuous
    add(1, 2'b10, 4'b1100, 1, mk(2'b10, 1, 1, 4'b0000, 2'b00, 0));
    add(1, 2'b10, 4'b1100, 1, mk(2'b00, 1, 0, 4'b1000, 2'b00, 0));
    add(1, 2'b10, 4'b1100, 1, mk(2'b00, 1, 0, 4'b0000, 2'b10, 1));
    add(1, 2'b10, 4'b1100, 1, mk(2'b10, 1, 1, 4'b0000, 2'b00, 0));
    add(1, 2'b10, 4'b1100, 1, mk(2'b00, 1, 0, 4'b1000, 2'b00, 0));
    add(1, 2'b10, 4'b1100, 1, mk(2'b00, 1, 0, 4'b0000, 2'b10, 1));
    add(1, 2'b00, 4'b1100, 1, Z);

    foreach (vecs[i]) begin
      reset_l = vecs[i].rst_l; req = vecs[i].req; addr = vecs[i].addr; rbl = vecs[i].rbl;
      tick();
      check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
    end

    // Out-of-range row on the NROWS=3 instance: no word line, bit reads as 1
    reset_l = 1'b0; tick();
    reset_l = 1'b1; req3 = 2'b01; addr3 = 4'b0011; rbl3 = 1'b0; tick();
    check("oor_pre", {27'd0, gnt3, pch3, rwl3}, {27'd0, 2'b01, 1'b1, 3'b000});
    req3 = 2'b00; tick();
    check("oor_eval", {28'd0, busy3, rwl3}, {28'd0, 1'b1, 3'b000});
    tick();
    check("oor_cap", {28'd0, rvalid3, rdata3, |rwl3}, {28'd0, 2'b01, 1'b1, 1'b0});
    tick();
    check("oor_idle", {31'd0, busy3}, 32'd0);

    // Precharge fault: rbl low on the last PRE edge
    reset_l = 1'b0; tick();
    check("pe_reset", {31'd0, pch_err}, 32'd0);
    reset_l = 1'b1; req = 2'b01; addr = 4'b0000; rbl = 1'b1; tick();
    rbl = 1'b0; req = 2'b00; tick();
    check("pe_eval", {27'd0, pch_err, rwl}, {27'd0, EXP_PE, 4'b0001});
    rbl = 1'b1; tick();
    check("pe_cap", {29'd0, rvalid, rdata}, {29'd0, 2'b01, 1'b1});
    tick();
    check("pe_hold", {30'd0, busy, pch_err}, {30'd0, 1'b0, EXP_PE});
    reset_l = 1'b0; tick();
    check("pe_clear", {31'd0, pch_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
